// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the memory stage
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_e;

   localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;
   localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter with terminal-count compare
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 16,
   localparam int unsigned W = $clog2(TIMEOUT + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic inc_i,
   output logic tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Counter falls back to zero whenever it is neither started nor advanced.
   always_comb begin
      cnt_d = '0;
      if (load_i) begin
         cnt_d = W'(1);
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == W'(TIMEOUT));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: EX/MEM to req/ack memory, stall and MEM/WB register
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] ALUdata_i,
   input  logic [31:0] MemWdata_i,
   input  logic [4:0]  RegWaddr_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        err_o,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic [31:0] ALUdata_o,
   output logic [31:0] MemRdata_o,
   output logic [4:0]  RegWaddr_o,
   output logic [31:0] stall_cnt_o
);

   state_e      state_q;
   logic        err_q;
   logic        access, misaligned, aligned_acc;
   logic        in_idle, in_wait, in_err;
   logic        complete, stall, tc, timer_load, timer_inc;

   logic        regwrite_q, regwrite_d;
   logic        memtoreg_q, memtoreg_d;
   logic [31:0] aludata_q, aludata_d;
   logic [31:0] memrdata_q, memrdata_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign access      = MemRead_i | MemWrite_i;
   assign misaligned  = |(ALUdata_i & WORD_ALIGN_MASK);
   assign aligned_acc = access & !misaligned;
   assign in_idle     = (state_q == IDLE);
   assign in_wait     = (state_q == WAIT);
   assign in_err      = (state_q == ERR);

   // Gating ack with req drops strays: after reset, or while idle with no access.
   assign mem_req_o   = !rst_i & ((in_idle & aligned_acc) | in_wait);
   assign complete    = mem_req_o & mem_ack_i;
   assign mem_we_o    = MemWrite_i;
   assign mem_addr_o  = ALUdata_i;
   assign mem_wdata_o = MemWdata_i;

   assign stall = (in_idle & aligned_acc & !mem_ack_i) | (in_wait & !mem_ack_i)
                | (in_idle & access & misaligned) | in_err;

   assign timer_load = !rst_i & in_idle & aligned_acc & !mem_ack_i;
   assign timer_inc  = in_wait & !mem_ack_i & !tc;

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (timer_load),
      .inc_i  (timer_inc),
      .tc_o   (tc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (access & misaligned) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else if (aligned_acc & !mem_ack_i) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               // An ack on the terminal-count cycle still wins over the timeout.
               if (mem_ack_i) begin
                  state_q <= IDLE;
               end else if (tc) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end
            end
            ERR: begin
               state_q <= ERR;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      regwrite_d = RegWrite_i;
      memtoreg_d = MemtoReg_i;
      aludata_d  = ALUdata_i;
      waddr_d    = RegWaddr_i;
      memrdata_d = (complete & MemRead_i & !MemWrite_i) ? mem_rdata_i : 32'd0;
      if (stall) begin
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         waddr_d    = 5'd0;
         aludata_d  = aludata_q;
         memrdata_d = memrdata_q;
      end
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         aludata_q   <= 32'd0;
         memrdata_q  <= 32'd0;
         waddr_q     <= 5'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         regwrite_q  <= regwrite_d;
         memtoreg_q  <= memtoreg_d;
         aludata_q   <= aludata_d;
         memrdata_q  <= memrdata_d;
         waddr_q     <= waddr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_o     = stall;
   assign err_o       = err_q;
   assign RegWrite_o  = regwrite_q;
   assign MemtoReg_o  = memtoreg_q;
   assign ALUdata_o   = aludata_q;
   assign MemRdata_o  = memrdata_q;
   assign RegWaddr_o  = waddr_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipelined-CPU memory stage and the consumer of the EX/MEM pipeline register. It turns the registered EX/MEM bundle into a req/ack transaction on a variable-latency data memory. While the transaction is outstanding it stalls the upstream pipeline. It drives the MEM/WB register, inserting bubbles while stalled, and latches a sticky fault on misalignment or memory timeout.

## Interface
- TIMEOUT, 16: maximum wait cycles after the request cycle before a timeout fault; legal range 2..255.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  EX/MEM control bits.
- ALUdata_i  in  32  address or ALU result.
- MemWdata_i  in  32  store data.
- RegWaddr_i  in  5  destination register.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address (= ALUdata_i).
- mem_wdata_o  out  32  store data.
- mem_ack_i  in  1  one-cycle completion pulse.
- mem_rdata_i  in  32  load data, valid with ack.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- err_o  out  1  sticky fault.
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control.
- ALUdata_o  out  32  MEM/WB ALU result.
- MemRdata_o  out  32  MEM/WB load data.
- RegWaddr_o  out  5  MEM/WB destination register.
- stall_cnt_o  out  32  saturating count of stalled cycles.

## Operation
- access = MemRead_i | MemWrite_i. If both bits are set, write wins: mem_we_o = MemWrite_i.
- FSM states: IDLE, WAIT, ERR.
  - IDLE, no access: pass-through, no request.
  - IDLE, access with ALUdata_i[1:0] != 0: go to ERR; no request is issued.
  - IDLE, aligned access, mem_ack_i=1: the access completes this cycle (zero-wait memory).
  - IDLE, aligned access, mem_ack_i=0: go to WAIT with wait_cnt=1.
  - WAIT, ack: complete and return to IDLE.
  - WAIT, no ack: wait_cnt increments; when wait_cnt = TIMEOUT without ack, go to ERR.
  - ERR: held until rst_i.
- mem_req_o = !rst_i & ((IDLE & aligned access) | WAIT). mem_addr_o, mem_wdata_o and mem_we_o are driven directly from the inputs, which stay stable because EX/MEM is frozen.
- stall_o = (IDLE & aligned access & !mem_ack_i) | (WAIT & !mem_ack_i) | (IDLE & misaligned access) | ERR. stall_o is combinational from mem_ack_i.
- Any ack sampled while mem_req_o=0 is ignored.
- MEM/WB update on each edge:
  - Not stalled: RegWrite_o, MemtoReg_o, ALUdata_o and RegWaddr_o load their inputs. MemRdata_o loads mem_rdata_i on a completing read, otherwise 0.
  - Stalled: bubble. RegWrite_o=0, MemtoReg_o=0, RegWaddr_o=0. ALUdata_o and MemRdata_o hold.
- err_o = ERR.
- stall_cnt_o increments on every stalled cycle and saturates at 0xFFFFFFFF.

## Timing
- Reset values: state IDLE, wait_cnt 0, every registered output 0, stall_cnt_o 0. mem_req_o is forced 0 during the reset cycle.
- Latency: a non-memory instruction passes to MEM/WB in 1 cycle. A memory access with ack N cycles after the request cycle stalls for N cycles, and MEM/WB updates on the ack edge.
- Handshake rules:
  - req stays high with stable addr/we/wdata until ack is sampled.
  - req drops in the cycle after ack unless the next EX/MEM entry is also an access. Back-to-back accesses keep req high continuously, with the new address on the cycle after ack.
- Reset mid-WAIT: abandon the transaction; req=0 in the reset cycle; a late ack after reset is ignored.
- Timeout boundary: an ack in the same cycle wait_cnt reaches TIMEOUT counts as success, not as a fault.

## Structure
- Shared package: FSM state enum (IDLE/WAIT/ERR), the word-alignment mask constant and the default TIMEOUT value.
- One sub-module, mem_wait_timer: wait counter plus terminal-count compare, width $clog2(TIMEOUT+1).
- The FSM, stall logic, MEM/WB register and stall counter stay in the top module.

## Test plan
- ALU op: RegWrite_i=1, ALUdata_i=0x1234, RegWaddr_i=5 → next edge RegWrite_o=1, ALUdata_o=0x1234, RegWaddr_o=5, stall_o never set.
- Zero-wait load: MemRead_i=1, ALUdata_i=0x40, ack in the same cycle with rdata=0xDEADBEEF → stall_o=0, MemRdata_o=0xDEADBEEF one edge later, stall_cnt_o=0.
- 3-wait store: MemWrite_i=1, addr=0x80, wdata=0xA5 → req/we/addr/wdata stable for 4 cycles, stall_o high for 3, three bubbles with RegWrite_o=0, stall_cnt_o=3.
- Misaligned load: ALUdata_i=0x42 → mem_req_o stays 0, err_o=1 next cycle, stall_o held; rst_i returns all outputs to 0.
- Timeout: TIMEOUT=4, no ack → err_o=1 after the request cycle plus 4 wait cycles. Repeat with ack exactly at wait_cnt=4 → success, err_o=0.
- Back-to-back loads to 0x10 and 0x14, each acked after 1 cycle → req continuous, two MEM/WB writes in order; rst_i mid-WAIT then a stray ack → ignored, state IDLE.
